// File: rtl/alu_rs_pkg.sv
// Shared widths, ALU op codes and entry/issue payload types for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned RS_SIZE = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned INST_W  = 6;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned REG_W   = 32;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned TAG_W   = 4;

  localparam logic [INST_W-1:0] INST_NOP   = 6'd0;
  localparam logic [INST_W-1:0] INST_LUI   = 6'd1;
  localparam logic [INST_W-1:0] INST_AUIPC = 6'd2;
  localparam logic [INST_W-1:0] INST_JAL   = 6'd3;
  localparam logic [INST_W-1:0] INST_JALR  = 6'd4;
  localparam logic [INST_W-1:0] INST_BEQ   = 6'd5;
  localparam logic [INST_W-1:0] INST_BNE   = 6'd6;
  localparam logic [INST_W-1:0] INST_BLT   = 6'd7;
  localparam logic [INST_W-1:0] INST_BGE   = 6'd8;
  localparam logic [INST_W-1:0] INST_BLTU  = 6'd9;
  localparam logic [INST_W-1:0] INST_BGEU  = 6'd10;
  localparam logic [INST_W-1:0] INST_ADDI  = 6'd11;
  localparam logic [INST_W-1:0] INST_SLTI  = 6'd12;
  localparam logic [INST_W-1:0] INST_SLTIU = 6'd13;
  localparam logic [INST_W-1:0] INST_XORI  = 6'd14;
  localparam logic [INST_W-1:0] INST_ORI   = 6'd15;
  localparam logic [INST_W-1:0] INST_ANDI  = 6'd16;
  localparam logic [INST_W-1:0] INST_SLLI  = 6'd17;
  localparam logic [INST_W-1:0] INST_SRLI  = 6'd18;
  localparam logic [INST_W-1:0] INST_SRAI  = 6'd19;
  localparam logic [INST_W-1:0] INST_ADD   = 6'd20;
  localparam logic [INST_W-1:0] INST_SUB   = 6'd21;
  localparam logic [INST_W-1:0] INST_SLL   = 6'd22;
  localparam logic [INST_W-1:0] INST_SLT   = 6'd23;
  localparam logic [INST_W-1:0] INST_SLTU  = 6'd24;
  localparam logic [INST_W-1:0] INST_XOR   = 6'd25;
  localparam logic [INST_W-1:0] INST_SRL   = 6'd26;
  localparam logic [INST_W-1:0] INST_SRA   = 6'd27;
  localparam logic [INST_W-1:0] INST_OR    = 6'd28;
  localparam logic [INST_W-1:0] INST_AND   = 6'd29;

  typedef struct packed {
    logic             rdy;
    logic [REG_W-1:0] val;
    logic [TAG_W-1:0] tag;
  } opnd_t;

  typedef struct packed {
    logic              busy;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] npc;
    logic [IMM_W-1:0]  imme;
    logic [TAG_W-1:0]  dest;
    opnd_t             rs1;
    opnd_t             rs2;
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] npc;
    logic [REG_W-1:0]  rs1_val;
    logic [REG_W-1:0]  rs2_val;
    logic [IMM_W-1:0]  imme;
    logic [TAG_W-1:0]  tag;
  } issue_t;

  // Capture a waiting operand from the CDB; the alu port wins if both match.
  function automatic opnd_t snoop(
    input opnd_t            o,
    input logic             a_v,
    input logic [TAG_W-1:0] a_t,
    input logic [REG_W-1:0] a_d,
    input logic             l_v,
    input logic [TAG_W-1:0] l_t,
    input logic [REG_W-1:0] l_d
  );
    opnd_t r;
    r = o;
    if (!o.rdy) begin
      if (a_v && (a_t == o.tag)) begin
        r.rdy = 1'b1;
        r.val = a_d;
      end else if (l_v && (l_t == o.tag)) begin
        r.rdy = 1'b1;
        r.val = l_d;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module rs_prio_enc #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan high to low so the lowest requester is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops the CDB for operands and
// issues the lowest-index ready entry into the combinational alu each cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              disp_valid,
  input  logic [INST_W-1:0] disp_inst,
  input  logic [ADDR_W-1:0] disp_npc,
  input  logic [IMM_W-1:0]  disp_imme,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic              disp_rs1_rdy,
  input  logic [REG_W-1:0]  disp_rs1_val,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic              disp_rs2_rdy,
  input  logic [REG_W-1:0]  disp_rs2_val,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  output logic              rs_full,
  input  logic              cdb_alu_valid,
  input  logic [TAG_W-1:0]  cdb_alu_tag,
  input  logic [REG_W-1:0]  cdb_alu_val,
  input  logic              cdb_lsb_valid,
  input  logic [TAG_W-1:0]  cdb_lsb_tag,
  input  logic [REG_W-1:0]  cdb_lsb_val,
  output logic              alu_valid,
  output logic [INST_W-1:0] alu_inst,
  output logic [ADDR_W-1:0] alu_npc,
  output logic [REG_W-1:0]  alu_rs1_val,
  output logic [REG_W-1:0]  alu_rs2_val,
  output logic [IMM_W-1:0]  alu_imme,
  output logic [TAG_W-1:0]  alu_tag
);

  entry_t             r_ent     [RS_SIZE];
  entry_t             w_ent_nxt [RS_SIZE];
  issue_t             r_iss;
  issue_t             w_iss_nxt;
  logic [RS_SIZE-1:0] w_busy;
  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_rdy_found;
  logic [IDX_W-1:0]   w_rdy_idx;
  opnd_t              w_new_rs1;
  opnd_t              w_new_rs2;

  always_comb begin
    w_busy  = '0;
    w_ready = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy & r_ent[i].rs1.rdy & r_ent[i].rs2.rdy;
    end
  end

  assign rs_full = &w_busy;

  rs_prio_enc #(.N(RS_SIZE), .IW(IDX_W)) u_free_enc (
    .req   (~w_busy),
    .found (w_free_found),
    .idx   (w_free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .IW(IDX_W)) u_rdy_enc (
    .req   (w_ready),
    .found (w_rdy_found),
    .idx   (w_rdy_idx)
  );

  // Incoming operands may be satisfied by a broadcast in the same cycle.
  always_comb begin
    w_new_rs1 = snoop('{rdy: disp_rs1_rdy, val: disp_rs1_val, tag: disp_rs1_tag},
                      cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
    w_new_rs2 = snoop('{rdy: disp_rs2_rdy, val: disp_rs2_val, tag: disp_rs2_tag},
                      cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
  end

  // Next-state: wakeup, issue of the selected entry, then dispatch into a free slot.
  always_comb begin
    w_ent_nxt = r_ent;
    w_iss_nxt = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (r_ent[i].busy) begin
        w_ent_nxt[i].rs1 = snoop(r_ent[i].rs1, cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                 cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
        w_ent_nxt[i].rs2 = snoop(r_ent[i].rs2, cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                 cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
      end
    end
    if (w_rdy_found) begin
      w_iss_nxt.valid   = 1'b1;
      w_iss_nxt.inst    = r_ent[w_rdy_idx].inst;
      w_iss_nxt.npc     = r_ent[w_rdy_idx].npc;
      w_iss_nxt.rs1_val = r_ent[w_rdy_idx].rs1.val;
      w_iss_nxt.rs2_val = r_ent[w_rdy_idx].rs2.val;
      w_iss_nxt.imme    = r_ent[w_rdy_idx].imme;
      w_iss_nxt.tag     = r_ent[w_rdy_idx].dest;
      w_ent_nxt[w_rdy_idx].busy = 1'b0;
    end
    if (disp_valid && w_free_found) begin
      w_ent_nxt[w_free_idx].busy = 1'b1;
      w_ent_nxt[w_free_idx].inst = disp_inst;
      w_ent_nxt[w_free_idx].npc  = disp_npc;
      w_ent_nxt[w_free_idx].imme = disp_imme;
      w_ent_nxt[w_free_idx].dest = disp_dest;
      w_ent_nxt[w_free_idx].rs1  = w_new_rs1;
      w_ent_nxt[w_free_idx].rs2  = w_new_rs2;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) r_ent[i] <= '0;
      r_iss <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < int'(RS_SIZE); i++) r_ent[i] <= '0;
        r_iss <= '0;
      end else begin
        r_ent <= w_ent_nxt;
        r_iss <= w_iss_nxt;
      end
    end
  end

  assign alu_valid   = r_iss.valid;
  assign alu_inst    = r_iss.inst;
  assign alu_npc     = r_iss.npc;
  assign alu_rs1_val = r_iss.rs1_val;
  assign alu_rs2_val = r_iss.rs2_val;
  assign alu_imme    = r_iss.imme;
  assign alu_tag     = r_iss.tag;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic against a slot-array model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, flush_in;
  logic              disp_valid;
  logic [INST_W-1:0] disp_inst;
  logic [ADDR_W-1:0] disp_npc;
  logic [IMM_W-1:0]  disp_imme;
  logic [TAG_W-1:0]  disp_dest;
  logic              disp_rs1_rdy, disp_rs2_rdy;
  logic [REG_W-1:0]  disp_rs1_val, disp_rs2_val;
  logic [TAG_W-1:0]  disp_rs1_tag, disp_rs2_tag;
  logic              rs_full;
  logic              cdb_alu_valid, cdb_lsb_valid;
  logic [TAG_W-1:0]  cdb_alu_tag, cdb_lsb_tag;
  logic [REG_W-1:0]  cdb_alu_val, cdb_lsb_val;
  logic              alu_valid;
  logic [INST_W-1:0] alu_inst;
  logic [ADDR_W-1:0] alu_npc;
  logic [REG_W-1:0]  alu_rs1_val, alu_rs2_val;
  logic [IMM_W-1:0]  alu_imme;
  logic [TAG_W-1:0]  alu_tag;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_inst(disp_inst), .disp_npc(disp_npc),
    .disp_imme(disp_imme), .disp_dest(disp_dest),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
    .alu_valid(alu_valid), .alu_inst(alu_inst), .alu_npc(alu_npc),
    .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val), .alu_imme(alu_imme), .alu_tag(alu_tag)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a table of slots, updated once per clock from the input rules.
  bit                m_busy  [RS_SIZE];
  logic [INST_W-1:0] m_inst  [RS_SIZE];
  logic [ADDR_W-1:0] m_npc   [RS_SIZE];
  logic [IMM_W-1:0]  m_imme  [RS_SIZE];
  logic [TAG_W-1:0]  m_dest  [RS_SIZE];
  bit                m_r1rdy [RS_SIZE];
  bit                m_r2rdy [RS_SIZE];
  logic [REG_W-1:0]  m_r1val [RS_SIZE];
  logic [REG_W-1:0]  m_r2val [RS_SIZE];
  logic [TAG_W-1:0]  m_r1tag [RS_SIZE];
  logic [TAG_W-1:0]  m_r2tag [RS_SIZE];
  logic [63:0]       e_valid, e_inst, e_npc, e_rs1, e_rs2, e_imme, e_tag;

  function automatic bit model_full();
    for (int i = 0; i < int'(RS_SIZE); i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic resolve(input bit rdy, input logic [REG_W-1:0] val, input logic [TAG_W-1:0] tag,
                         output bit nrdy, output logic [REG_W-1:0] nval);
    nrdy = rdy;
    nval = val;
    if (!rdy && cdb_alu_valid && cdb_alu_tag == tag) begin
      nrdy = 1'b1; nval = cdb_alu_val;
    end else if (!rdy && cdb_lsb_valid && cdb_lsb_tag == tag) begin
      nrdy = 1'b1; nval = cdb_lsb_val;
    end
  endtask

  task automatic clear_out();
    e_valid = 0; e_inst = 0; e_npc = 0; e_rs1 = 0; e_rs2 = 0; e_imme = 0; e_tag = 0;
  endtask

  task automatic model_step();
    int sel, fr;
    if (rst_in || (rdy_in && flush_in)) begin
      for (int i = 0; i < int'(RS_SIZE); i++) m_busy[i] = 1'b0;
      clear_out();
      return;
    end
    if (!rdy_in) return;
    sel = -1;
    fr  = -1;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (sel < 0 && m_busy[i] && m_r1rdy[i] && m_r2rdy[i]) sel = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    clear_out();
    if (sel >= 0) begin
      e_valid = 1; e_inst = 64'(m_inst[sel]); e_npc = 64'(m_npc[sel]);
      e_rs1 = 64'(m_r1val[sel]); e_rs2 = 64'(m_r2val[sel]);
      e_imme = 64'(m_imme[sel]); e_tag = 64'(m_dest[sel]);
      m_busy[sel] = 1'b0;
    end
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (m_busy[i]) begin
        resolve(m_r1rdy[i], m_r1val[i], m_r1tag[i], m_r1rdy[i], m_r1val[i]);
        resolve(m_r2rdy[i], m_r2val[i], m_r2tag[i], m_r2rdy[i], m_r2val[i]);
      end
    end
    if (disp_valid && fr >= 0) begin
      m_busy[fr] = 1'b1; m_inst[fr] = disp_inst; m_npc[fr] = disp_npc;
      m_imme[fr] = disp_imme; m_dest[fr] = disp_dest;
      m_r1tag[fr] = disp_rs1_tag; m_r2tag[fr] = disp_rs2_tag;
      resolve(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag, m_r1rdy[fr], m_r1val[fr]);
      resolve(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag, m_r2rdy[fr], m_r2val[fr]);
    end
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; flush_in = 0; disp_valid = 0;
    cdb_alu_valid = 0; cdb_lsb_valid = 0;
  endtask

  task automatic disp(input logic [INST_W-1:0] inst, input logic [TAG_W-1:0] dest,
                      input bit r1rdy, input logic [REG_W-1:0] r1val, input logic [TAG_W-1:0] r1tag,
                      input bit r2rdy, input logic [REG_W-1:0] r2val, input logic [TAG_W-1:0] r2tag,
                      input logic [IMM_W-1:0] imme);
    disp_valid = 1; disp_inst = inst; disp_dest = dest; disp_imme = imme;
    disp_npc = $urandom;
    disp_rs1_rdy = r1rdy; disp_rs1_val = r1val; disp_rs1_tag = r1tag;
    disp_rs2_rdy = r2rdy; disp_rs2_val = r2val; disp_rs2_tag = r2tag;
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc();
    model_step();
    @(posedge clk_in);
    #1;
    check_eq("alu_valid", 64'(alu_valid), e_valid);
    check_eq("alu_inst", 64'(alu_inst), e_inst);
    check_eq("alu_npc", 64'(alu_npc), e_npc);
    check_eq("alu_rs1_val", 64'(alu_rs1_val), e_rs1);
    check_eq("alu_rs2_val", 64'(alu_rs2_val), e_rs2);
    check_eq("alu_imme", 64'(alu_imme), e_imme);
    check_eq("alu_tag", 64'(alu_tag), e_tag);
    check_eq("rs_full", 64'(rs_full), 64'(model_full()));
  endtask

  initial begin
    idle();
    disp_inst = 0; disp_npc = 0; disp_imme = 0; disp_dest = 0;
    disp_rs1_rdy = 0; disp_rs1_val = 0; disp_rs1_tag = 0;
    disp_rs2_rdy = 0; disp_rs2_val = 0; disp_rs2_tag = 0;
    cdb_alu_tag = 0; cdb_alu_val = 0; cdb_lsb_tag = 0; cdb_lsb_val = 0;

    // reset, then a ready addi issues one cycle after it is written
    rst_in = 1; cyc();
    check_eq("rst_valid", 64'(alu_valid), 64'd0);
    check_eq("rst_full", 64'(rs_full), 64'd0);
    idle(); disp(INST_ADDI, 4'd2, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0, 32'd3); cyc();
    check_eq("t1_early", 64'(alu_valid), 64'd0);
    idle(); cyc();
    check_eq("t1_valid", 64'(alu_valid), 64'd1);
    check_eq("t1_inst", 64'(alu_inst), 64'(INST_ADDI));
    check_eq("t1_rs1", 64'(alu_rs1_val), 64'd5);
    check_eq("t1_imme", 64'(alu_imme), 64'd3);
    check_eq("t1_tag", 64'(alu_tag), 64'd2);

    // rs1 waits on tag 7, woken by the load port
    idle(); disp(INST_ADD, 4'd5, 0, 32'd0, 4'd7, 1, 32'd1, 4'd0, 32'd0); cyc();
    idle(); cyc(); check_eq("t2_wait1", 64'(alu_valid), 64'd0);
    cyc(); check_eq("t2_wait2", 64'(alu_valid), 64'd0);
    cdb_lsb_valid = 1; cdb_lsb_tag = 4'd7; cdb_lsb_val = 32'h10; cyc();
    check_eq("t2_wait3", 64'(alu_valid), 64'd0);
    idle(); cyc();
    check_eq("t2_valid", 64'(alu_valid), 64'd1);
    check_eq("t2_rs1", 64'(alu_rs1_val), 64'h10);

    // same-cycle forward from the alu port into a dispatching entry
    idle(); disp(INST_SUB, 4'd6, 1, 32'd8, 4'd0, 0, 32'd0, 4'd4, 32'd0);
    cdb_alu_valid = 1; cdb_alu_tag = 4'd4; cdb_alu_val = 32'd9; cyc();
    idle(); cyc();
    check_eq("t3_valid", 64'(alu_valid), 64'd1);
    check_eq("t3_rs2", 64'(alu_rs2_val), 64'd9);

    // fill all slots, reject the overflow, free slot 3 and refill it
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      idle(); disp(INST_ADD, TAG_W'(i), 0, 32'd0, TAG_W'(i), 1, 32'd0, 4'd0, 32'd0); cyc();
    end
    check_eq("t4_full", 64'(rs_full), 64'd1);
    idle(); disp(INST_ADDI, 4'd15, 1, 32'd1, 4'd0, 1, 32'd0, 4'd0, 32'd1); cyc();
    idle(); cyc();
    check_eq("t4_overflow", 64'(alu_valid), 64'd0);
    cdb_alu_valid = 1; cdb_alu_tag = 4'd3; cdb_alu_val = 32'h33; cyc();
    idle(); cyc();
    check_eq("t4_issue_tag", 64'(alu_tag), 64'd3);
    check_eq("t4_issue_rs1", 64'(alu_rs1_val), 64'h33);
    check_eq("t4_notfull", 64'(rs_full), 64'd0);
    idle(); disp(INST_ADD, 4'd3, 0, 32'd0, 4'd3, 1, 32'd0, 4'd0, 32'd0); cyc();
    check_eq("t4_refull", 64'(rs_full), 64'd1);

    // two entries woken together issue lowest index first
    idle(); cdb_alu_valid = 1; cdb_alu_tag = 4'd2; cdb_alu_val = 32'h22;
    cdb_lsb_valid = 1; cdb_lsb_tag = 4'd9; cdb_lsb_val = 32'h99; cyc();
    idle(); cyc();
    check_eq("t5_first", 64'(alu_tag), 64'd2);
    cyc();
    check_eq("t5_second", 64'(alu_tag), 64'd9);
    check_eq("t5_second_rs1", 64'(alu_rs1_val), 64'h99);

    // rdy_in hold, then flush with a concurrent dispatch
    idle(); rst_in = 1; cyc();
    for (int i = 0; i < 5; i++) begin
      idle(); disp(INST_ADD, TAG_W'(i), 0, 32'd0, TAG_W'(i), 1, 32'd0, 4'd0, 32'd0); cyc();
    end
    idle(); rdy_in = 0; disp(INST_ADDI, 4'd8, 1, 32'd1, 4'd0, 1, 32'd0, 4'd0, 32'd0);
    cdb_alu_valid = 1; cdb_alu_tag = 4'd0; cdb_alu_val = 32'h5; cyc();
    idle(); cyc();
    check_eq("t6_hold", 64'(alu_valid), 64'd0);
    idle(); flush_in = 1; disp(INST_ADDI, 4'd8, 1, 32'd1, 4'd0, 1, 32'd0, 4'd0, 32'd0); cyc();
    check_eq("t6_flush_valid", 64'(alu_valid), 64'd0);
    idle(); cdb_alu_valid = 1; cdb_alu_tag = 4'd0; cdb_lsb_valid = 1; cdb_lsb_tag = 4'd1; cyc();
    idle(); cyc();
    check_eq("t6_dropped", 64'(alu_valid), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_in   = ($urandom_range(0, 299) == 0);
      flush_in = ($urandom_range(0, 59) == 0);
      rdy_in   = ($urandom_range(0, 7) != 0);
      if (!model_full() && $urandom_range(0, 1) == 1)
        disp(INST_W'($urandom_range(1, 29)), TAG_W'($urandom),
             1'($urandom_range(0, 1)), $urandom, TAG_W'($urandom),
             1'($urandom_range(0, 1)), $urandom, TAG_W'($urandom), $urandom);
      cdb_alu_valid = ($urandom_range(0, 2) == 0);
      cdb_alu_tag = TAG_W'($urandom); cdb_alu_val = $urandom;
      cdb_lsb_valid = ($urandom_range(0, 2) == 0);
      cdb_lsb_tag = TAG_W'($urandom); cdb_lsb_val = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
